// File: rtl/wait_time_est.sv
// Queue wait-time estimator: wtime = ceil(pcount * T_SVC / tellers), computed by a
// multi-cycle restoring divider behind a start/done handshake, with err/sat flags.
module wait_time_est #(
   parameter int CNT_W = 3,
   parameter int TLR_W = 2,
   parameter int T_SVC = 3,
   parameter int OUT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] pcount,
   input  logic [TLR_W-1:0] tellers,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] wtime,
   output logic             err,
   output logic             sat
);

   localparam int PROD_W = CNT_W + $clog2(T_SVC + 1);
   localparam int ITER_W = $clog2(PROD_W + 1);
   localparam logic [31:0] OUT_MAX = 32'((1 << OUT_W) - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [PROD_W-1:0] dq_q, dq_d;
   logic [TLR_W:0]    rem_q, rem_d;
   logic [TLR_W-1:0]  tlr_q, tlr_d;
   logic [ITER_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [OUT_W-1:0]  wtime_q, wtime_d;
   logic              err_q, err_d;
   logic              sat_q, sat_d;

   logic [PROD_W-1:0] prod;
   logic [TLR_W+1:0]  rem_sh, rem_nx;
   logic [TLR_W+2:0]  diff;
   logic              fits;
   logic              rem_nz;
   logic [PROD_W-1:0] dq_nx;
   logic [PROD_W:0]   qp;
   logic [31:0]       qp_ext;

   // dq holds the dividend at load and shifts quotient bits in from the LSB.
   always_comb begin
      prod   = PROD_W'(pcount) * PROD_W'(T_SVC);
      rem_sh = {rem_q, dq_q[PROD_W-1]};
      diff   = {1'b0, rem_sh} - {3'b000, tlr_q};
      fits   = ~diff[TLR_W+2];
      rem_nx = fits ? diff[TLR_W+1:0] : rem_sh;
      rem_nz = |rem_nx;
      dq_nx  = {dq_q[PROD_W-2:0], fits};
      qp     = {1'b0, dq_nx} + {{PROD_W{1'b0}}, rem_nz};
      qp_ext = 32'(qp);
   end

   // Result is resolved on the last DIV edge so it is registered and visible in FIN.
   always_comb begin
      state_d = state_q;
      dq_d    = dq_q;
      rem_d   = rem_q;
      tlr_d   = tlr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      wtime_d = wtime_q;
      err_d   = err_q;
      sat_d   = sat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               tlr_d   = tellers;
               dq_d    = prod;
               rem_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            dq_d  = dq_nx;
            rem_d = rem_nx[TLR_W:0];
            cnt_d = cnt_q + ITER_W'(1);
            if (cnt_q == ITER_W'(PROD_W - 1)) begin
               state_d = S_FIN;
               done_d  = 1'b1;
               if (tlr_q == '0) begin
                  wtime_d = '1;
                  err_d   = 1'b1;
                  sat_d   = 1'b0;
               end else if (qp_ext > OUT_MAX) begin
                  wtime_d = '1;
                  err_d   = 1'b0;
                  sat_d   = 1'b1;
               end else begin
                  wtime_d = qp_ext[OUT_W-1:0];
                  err_d   = 1'b0;
                  sat_d   = 1'b0;
               end
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         dq_q    <= '0;
         rem_q   <= '0;
         tlr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wtime_q <= '0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dq_q    <= dq_d;
         rem_q   <= rem_d;
         tlr_q   <= tlr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wtime_q <= wtime_d;
         err_q   <= err_d;
         sat_q   <= sat_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign wtime = wtime_q;
   assign err   = err_q;
   assign sat   = sat_q;

endmodule

// File: tb/tb_wait_time_est.sv
// Directed bench for wait_time_est: default instance plus an OUT_W=4 instance sharing
// the same stimulus, so the saturation cases can be observed on the narrow output.
module tb_wait_time_est;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] pcount = '0;
   logic [1:0] tellers = '0;

   logic       busy, done, err, sat;
   logic [4:0] wtime;
   logic       busy4, done4, err4, sat4;
   logic [3:0] wtime4;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   wait_time_est dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pcount(pcount), .tellers(tellers),
      .busy(busy), .done(done), .wtime(wtime), .err(err), .sat(sat)
   );

   wait_time_est #(.OUT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .pcount(pcount), .tellers(tellers),
      .busy(busy4), .done(done4), .wtime(wtime4), .err(err4), .sat(sat4)
   );

   always @(negedge clk) if (done) done_cnt++;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [2:0] p, input logic [1:0] t);
      @(negedge clk);
      pcount = p;
      tellers = t;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called just after the accepting edge; returns the cycle index in which done is seen.
   task automatic wait_done(input int first, output int cyc, output bit busy_ok);
      cyc = first;
      busy_ok = busy;
      while (!done && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         busy_ok = busy_ok & busy;
      end
   endtask

   task automatic run_est(input string tag, input logic [2:0] p, input logic [1:0] t,
                          input logic [4:0] exp_w, input logic exp_e, input logic exp_s);
      int cyc;
      bit bok;
      logic [4:0] e;
      exp_q.push_back(exp_w);
      launch(p, t);
      wait_done(1, cyc, bok);
      e = exp_q.pop_front();
      check({tag, " latency"}, cyc, 6);
      check({tag, " busy"}, bok, 1);
      check({tag, " wtime"}, wtime, e);
      check({tag, " err"}, err, exp_e);
      check({tag, " sat"}, sat, exp_s);
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, done, 0);
      check({tag, " busy_off"}, busy, 0);
   endtask

   initial begin
      int cyc;
      bit bok;
      int d0;

      #12;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst wtime", wtime, 0);
      check("rst err", err, 0);
      check("rst sat", sat, 0);
      check("rst wtime4", wtime4, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_est("p7t1", 3'd7, 2'd1, 5'd21, 1'b0, 1'b0);
      check("p7t1 w4", wtime4, 15);
      check("p7t1 sat4", sat4, 1);
      check("p7t1 err4", err4, 0);

      run_est("p5t2", 3'd5, 2'd2, 5'd8, 1'b0, 1'b0);
      run_est("p7t3", 3'd7, 2'd3, 5'd7, 1'b0, 1'b0);
      run_est("p0t3", 3'd0, 2'd3, 5'd0, 1'b0, 1'b0);

      run_est("p4t0", 3'd4, 2'd0, 5'd31, 1'b1, 1'b0);
      check("p4t0 w4", wtime4, 15);
      check("p4t0 err4", err4, 1);
      check("p4t0 sat4", sat4, 0);

      run_est("p2t1", 3'd2, 2'd1, 5'd6, 1'b0, 1'b0);

      run_est("p5t1", 3'd5, 2'd1, 5'd15, 1'b0, 1'b0);
      check("p5t1 w4", wtime4, 15);
      check("p5t1 sat4", sat4, 0);
      check("p5t1 err4", err4, 0);

      // start while busy and on the done cycle must both be ignored
      d0 = done_cnt;
      launch(3'd6, 2'd1);
      @(negedge clk);
      pcount = 3'd1;
      tellers = 2'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(2, cyc, bok);
      check("busy_start latency", cyc, 6);
      check("busy_start busy", bok, 1);
      check("busy_start wtime", wtime, 18);
      @(negedge clk);
      pcount = 3'd1;
      tellers = 2'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      check("done_cycle_start busy", busy, 0);
      check("done_cycle_start done", done, 0);
      check("done_cycle_start wtime", wtime, 18);
      check("busy_start one_done", done_cnt - d0, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("next_start accepted", busy, 1);
      wait_done(1, cyc, bok);
      check("next_start latency", cyc, 6);
      check("next_start wtime", wtime, 1);
      @(posedge clk);
      #1;

      // asynchronous reset in the middle of a division
      launch(3'd7, 2'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort wtime", wtime, 0);
      check("abort err", err, 0);
      check("abort sat", sat, 0);
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("abort no_done", done_cnt - d0, 0);
      check("abort idle", busy, 0);

      run_est("p3t1", 3'd3, 2'd1, 5'd9, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wait_time_est.md
# wait_time_est

Parametrised, sequential estimator of a customer's expected waiting time in the bank queue system. It replaces the fixed 3-bit-count / 2-bit-teller lookup with a computed estimate. The estimate is wtime = ceil(pcount × T_SVC / tellers), produced by a multi-cycle restoring divider behind a start/done handshake. It sits between the queue counter / teller-select logic and the display driver, and adds error and saturation flags.

## Interface
- CNT_W, default 3: width of the people-in-queue count.
- TLR_W, default 2: width of the active-teller count.
- T_SVC, default 3: service time per customer, in minutes; constant ≥ 1.
- OUT_W, default 5: width of the wait-time output.
- PROD_W, derived, never overridden: CNT_W + $clog2(T_SVC+1). It is 5 at the defaults.
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new estimate; sampled only in IDLE.
- pcount  input  CNT_W  people in queue; captured on accepted start.
- tellers  input  TLR_W  active tellers; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; wtime, err and sat are valid and updated in that cycle.
- wtime  output  OUT_W  estimated wait in minutes; held until the next done.
- err  output  1  tellers was 0 for the last estimate; held until the next done.
- sat  output  1  true result exceeded 2^OUT_W−1; held until the next done.

## Operation
- FSM states: IDLE, DIV, FIN.
- IDLE:
  - On start=1, latch pcount and tellers.
  - Load the dividend as prod = pcount × T_SVC, PROD_W bits, never truncated.
  - Clear the partial remainder and the iteration counter; set busy=1; go to DIV.
  - start=0 holds IDLE.
- DIV: restoring division, one quotient bit per cycle, MSB first.
  - The remainder register is TLR_W+1 bits.
  - Runs exactly PROD_W iterations, then goes to FIN.
  - Divisor 0 is not special-cased in the datapath; FIN discards that result.
- FIN: result resolution, in priority order:
  1. If latched tellers == 0: wtime = all ones, err = 1, sat = 0.
  2. Otherwise q' = quotient + (remainder ≠ 0).
  3. If q' > 2^OUT_W−1: wtime = all ones, sat = 1; else wtime = q'[OUT_W-1:0], sat = 0. In both cases err = 0.
  - Then: done = 1 for this cycle only, busy = 0, next state IDLE.
- pcount = 0: no fast path. It takes the full latency and gives wtime = 0, err = 0, sat = 0.
- start while busy (DIV or FIN): ignored and not queued. Inputs are captured only in IDLE.
- start on the cycle done is high: the FSM is still in FIN, so the request is ignored. A new start is accepted on the following cycle.
- Inputs changing after capture have no effect on the running estimate.
- rst_n low at any time, including mid-division:
  - State goes to IDLE immediately, asynchronously.
  - wtime = 0, err = 0, sat = 0, busy = 0, done = 0; all internal registers = 0.
  - The aborted estimate produces no done.

## Timing
- Let start be sampled high on edge E0.
- busy is high after E0 through the DIV and FIN cycles. It is low after edge E0+PROD_W+1.
- DIV occupies edges E0+1 … E0+PROD_W.
- FIN is entered after edge E0+PROD_W. done, the updated wtime and the flags are visible in the cycle after that edge.
- Latency from start sample to done-high cycle: PROD_W+1 cycles. This is 6 cycles at the defaults, and it is identical for every input value.
- Throughput: one estimate per PROD_W+2 cycles at best, because of the IDLE re-entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: busy = 0, done = 0, wtime = 0, err = 0, sat = 0.

## Test plan
- Defaults, pcount=7, tellers=1 → done exactly 6 cycles after start; wtime=21, err=0, sat=0; busy high for those 6 cycles.
- Defaults, pcount=5, tellers=2 → wtime=8 (ceil 15/2). Then pcount=7, tellers=3 → wtime=7. Then pcount=0, tellers=3 → wtime=0 with the same latency.
- Defaults, tellers=0, pcount=4 → wtime=31, err=1, sat=0. A following pcount=2, tellers=1 → wtime=6, err=0.
- OUT_W=4, pcount=7, tellers=1 → wtime=15, sat=1, err=0. With pcount=5, tellers=1 → wtime=15, sat=0.
- Defaults, start pcount=6, tellers=1. Assert start again with pcount=1, tellers=3 on cycle 2 of busy and again on the done cycle. Required: exactly one done, wtime=18. A start one cycle after done is accepted.
- Defaults, start pcount=7, tellers=1. Pull rst_n low on cycle 3 of DIV. Required: busy, done, wtime, err and sat = 0 immediately without a clock edge, and no done later. After release, pcount=3, tellers=1 → wtime=9.
